// File: rtl/aoi2n2_sched_pkg.sv
// Shared types and helpers for the AOI2N2 round-robin scheduler.
// Z = ~((A&B) | ~(C|D)) evaluated on a 4-bit operand {A,B,C,D}.
package aoi2n2_sched_pkg;

    // Output slot occupancy
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } sched_state_t;

    localparam int unsigned DEF_NUM_REQ = 4;

    // abcd = {A,B,C,D}, A is the MSB
    function automatic logic aoi2n2_eval(input logic [3:0] abcd);
        return ~((abcd[3] & abcd[2]) | ~(abcd[1] | abcd[0]));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans upward from LAST+1 (wrapping) and grants
// the first requester found. GNT is one-hot, or zero when EN is low.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] REQ,
    input  logic [ID_W-1:0]    LAST,
    input  logic               EN,
    output logic [NUM_REQ-1:0] GNT
);

    logic            found;
    logic [ID_W-1:0] pos;

    // Priority scan starting just after the last winner
    always_comb begin
        GNT   = '0;
        found = 1'b0;
        pos   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            pos = ID_W'((32'(LAST) + k) % NUM_REQ);
            if (EN && !found && REQ[pos]) begin
                GNT[pos] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aoi2n2_rr_scheduler.sv
// Round-robin scheduler sharing one AOI2N2 evaluator among NUM_REQ
// requesters, with a one-deep registered, ID-tagged result slot.
// Optional macro AOI2N2_GRANT_CNT_EN adds a saturating transfer
// counter on port GRANT_CNT (width CNT_W).
module aoi2n2_rr_scheduler
    import aoi2n2_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
`ifdef AOI2N2_GRANT_CNT_EN
    ,
    parameter int unsigned CNT_W   = 16
`endif
) (
    input  logic                 CP,
    input  logic                 RST,
    input  logic [NUM_REQ-1:0]   REQ_VALID,
    input  logic [4*NUM_REQ-1:0] REQ_DATA,
    output logic [NUM_REQ-1:0]   REQ_READY,
    output logic                 OUT_VALID,
    output logic                 OUT_Z,
    output logic [ID_W-1:0]      OUT_ID,
    input  logic                 OUT_READY
`ifdef AOI2N2_GRANT_CNT_EN
    ,
    output logic [CNT_W-1:0]     GRANT_CNT
`endif
);

    sched_state_t        state_q, state_d;
    logic [ID_W-1:0]     last_q;
    logic [NUM_REQ-1:0]  gnt;
    logic                free;
    logic                arb_en;
    logic                xfer;
    logic [ID_W-1:0]     sel_id;
    logic [3:0]          sel_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .REQ  (REQ_VALID),
        .LAST (last_q),
        .EN   (arb_en),
        .GNT  (gnt)
    );

    // Slot availability, handshake outputs and grant decode
    always_comb begin
        OUT_VALID = (state_q == ST_FULL);
        free      = !OUT_VALID || OUT_READY;
        arb_en    = free && !RST;
        REQ_READY = gnt;
        xfer      = |gnt;
        sel_id    = '0;
        sel_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_id   = ID_W'(i);
                sel_data = 4'(REQ_DATA >> (4 * i));
            end
        end
    end

    // Next occupancy: fill on accept, empty only on drain without accept
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (xfer) state_d = ST_FULL;
            ST_FULL:  if (OUT_READY && !xfer) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Occupancy register
    always_ff @(posedge CP) begin
        if (RST) state_q <= ST_EMPTY;
        else     state_q <= state_d;
    end

    // Result register and round-robin pointer, updated only on transfer
    always_ff @(posedge CP) begin
        if (RST) begin
            OUT_Z  <= 1'b0;
            OUT_ID <= '0;
            last_q <= ID_W'(NUM_REQ - 1);
        end else if (xfer) begin
            OUT_Z  <= aoi2n2_eval(sel_data);
            OUT_ID <= sel_id;
            last_q <= sel_id;
        end
    end

`ifdef AOI2N2_GRANT_CNT_EN
    // Saturating count of transfers
    always_ff @(posedge CP) begin
        if (RST)                        GRANT_CNT <= '0;
        else if (xfer && GRANT_CNT != '1) GRANT_CNT <= GRANT_CNT + 1'b1;
    end
`endif

endmodule

// File: tb/tb_aoi2n2_rr_scheduler.sv
// Scoreboard bench for aoi2n2_rr_scheduler: a reference model predicts
// grants and results, a monitor compares the DUT output port.
module tb_aoi2n2_rr_scheduler;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic           CP = 1'b0;
    logic           RST;
    logic [N-1:0]   REQ_VALID;
    logic [4*N-1:0] REQ_DATA;
    logic [N-1:0]   REQ_READY;
    logic           OUT_VALID;
    logic           OUT_Z;
    logic [IDW-1:0] OUT_ID;
    logic           OUT_READY;
`ifdef AOI2N2_GRANT_CNT_EN
    logic [3:0]     GRANT_CNT;
`endif

    aoi2n2_rr_scheduler #(
        .NUM_REQ (N)
`ifdef AOI2N2_GRANT_CNT_EN
        , .CNT_W (4)
`endif
    ) dut (
        .CP        (CP),
        .RST       (RST),
        .REQ_VALID (REQ_VALID),
        .REQ_DATA  (REQ_DATA),
        .REQ_READY (REQ_READY),
        .OUT_VALID (OUT_VALID),
        .OUT_Z     (OUT_Z),
        .OUT_ID    (OUT_ID),
        .OUT_READY (OUT_READY)
`ifdef AOI2N2_GRANT_CNT_EN
        , .GRANT_CNT (GRANT_CNT)
`endif
    );

    always #5 CP = ~CP;

    typedef struct {
        int   id;
        logic z;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model state
    bit   exp_full = 0;
    int   exp_last = N - 1;
    int   exp_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic ref_z(input logic [3:0] v);
        if (v[3] && v[2]) return 1'b0;   // A&B forces 0
        return v[1] || v[0];             // otherwise 1 iff C or D
    endfunction

    // Reference model: occupancy, rotating priority, expected grants
    always @(negedge CP) begin
        int winner;
        logic [N-1:0] exp_ready;
`ifdef AOI2N2_GRANT_CNT_EN
        check("grant_cnt", 32'(GRANT_CNT), 32'(exp_cnt));
`endif
        if (RST) begin
            check("ready_in_reset", 32'(REQ_READY), 32'd0);
            exp_full = 0;
            exp_last = N - 1;
            exp_cnt  = 0;
            sb_q.delete();
        end else begin
            check("out_valid", 32'(OUT_VALID), 32'(exp_full));
            winner = -1;
            if (!exp_full || OUT_READY) begin
                for (int k = 1; k <= N; k++) begin
                    int r;
                    r = (exp_last + k) % N;
                    if (REQ_VALID[r]) begin
                        winner = r;
                        break;
                    end
                end
            end
            exp_ready = '0;
            if (winner >= 0) exp_ready[winner] = 1'b1;
            check("req_ready", 32'(REQ_READY), 32'(exp_ready));
            if (winner >= 0) begin
                logic [3:0] nib;
                nib = 4'(REQ_DATA >> (4 * winner));
                sb_q.push_back('{id: winner, z: ref_z(nib)});
                exp_last = winner;
                exp_full = 1;
                if (exp_cnt < 15) exp_cnt++;
            end else if (exp_full && OUT_READY) begin
                exp_full = 0;
            end
        end
    end

    // Monitor: compare presented result with the oldest expectation
    always @(negedge CP) begin
        if (!RST && OUT_VALID) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=id%0d required=none at %0t", OUT_ID, $time);
            end else begin
                check("out_id", 32'(OUT_ID), 32'(sb_q[0].id));
                check("out_z", 32'(OUT_Z), 32'(sb_q[0].z));
                if (OUT_READY) void'(sb_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge CP);
        #1;
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1; REQ_VALID = '0; REQ_DATA = '0; OUT_READY = 1'b0;
        step(); step();
        RST = 1'b0;
        step();
        @(negedge CP);
        check("reset_out_id", 32'(OUT_ID), 32'd0);
        check("reset_out_z", 32'(OUT_Z), 32'd0);

        // Truth table through requester 2
        @(posedge CP); #1;
        OUT_READY = 1'b1;
        for (int v = 0; v < 16; v++) begin
            REQ_VALID = 4'b0100;
            REQ_DATA  = 16'(v) << 8;
            step();
        end
        REQ_VALID = '0;
        step(); step();

        // Round-robin with all requesters valid
        for (int c = 0; c < 6; c++) begin
            REQ_VALID = 4'b1111;
            REQ_DATA  = 16'($urandom);
            step();
        end
        REQ_VALID = '0;
        step();

        // Backpressure: accept requester 1, stall three cycles, release
        REQ_VALID = 4'b0010; REQ_DATA = 16'h00b0; OUT_READY = 1'b1;
        step();
        REQ_VALID = 4'b0110; REQ_DATA = 16'h0ab0; OUT_READY = 1'b0;
        step(); step(); step();
        OUT_READY = 1'b1;
        step();
        REQ_VALID = '0;
        step(); step();

        // Mid-operation reset with a stalled result
        REQ_VALID = 4'b0001; REQ_DATA = 16'h0003; OUT_READY = 1'b0;
        step();
        REQ_VALID = 4'b1001; REQ_DATA = 16'h3003;
        step();
        RST = 1'b1;
        step();
        RST = 1'b0; OUT_READY = 1'b1;
        step();
        REQ_VALID = '0;
        step();

        // Twenty back-to-back transfers
        for (int c = 0; c < 20; c++) begin
            REQ_VALID = 4'(1 << (c % N)) | 4'($urandom);
            REQ_DATA  = 16'($urandom);
            step();
        end

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            RST       = ($urandom_range(0, 63) == 0);
            REQ_VALID = 4'($urandom);
            REQ_DATA  = 16'($urandom);
            OUT_READY = ($urandom_range(0, 3) != 0);
            step();
        end

        // Drain
        RST = 1'b0; REQ_VALID = '0; OUT_READY = 1'b1;
        step(); step(); step();
        @(negedge CP);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
